output_controller_nvc: RTL and testbench
========================================

// Module: output_controller_nvc
// PURPOSE
//  Parametrised output-port controller for the mesh router.
//  N_IN input sources compete through a round-robin arbiter for one output link.
//  The link is fed by two per-VC FIFOs of DEPTH flits each, instead of a single 1-flit buffer.
//  VC timeslots are polarity-driven: flits of VC==polarity may enter; flits of VC!=polarity may leave.
// PARAMETERS
//  N_IN    4   number of input sources feeding this output (>=2)
//  DW      64  flit width in bits
//  VC_BIT  63  bit index of the VC flag inside a flit (0..DW-1)
//  DEPTH   2   per-VC FIFO depth in flits (power of two, >=2)
// PORTS
//  clk        in   1               clock, rising edge
//  reset      in   1               asynchronous, active-high reset
//  polarity   in   1               VC timeslot selector
//  in_si      in   N_IN            per-source valid
//  in_di      in   N_IN*DW         per-source flit; source i occupies bits [i*DW +: DW]
//  in_ri      out  N_IN            per-source ready
//  out_so     out  1               link valid
//  out_do     out  DW              link flit
//  out_ro     in   1               link ready
//  occ_vc0    out  clog2(DEPTH)+1  VC0 FIFO occupancy
//  occ_vc1    out  clog2(DEPTH)+1  VC1 FIFO occupancy
// BEHAVIOUR
//  Reset (async, high):
//   - Both FIFOs are emptied and all read/write pointers cleared.
//   - The RR pointer is set to 0; occ_vc0 and occ_vc1 read 0.
//   - in_ri and out_so are forced to 0 for as long as reset is high, including mid-transfer; any in-flight flit is dropped.
//  Ingress (combinational grant, registered push):
//   - elig[i] = in_si[i] && (flit_i[VC_BIT]==polarity). Flits of the other VC get no ready and are held upstream.
//   - The arbiter grants exactly one eligible source: the first one at or after ptr, searching upward modulo N_IN.
//   - in_ri[i] = grant[i] && !full[polarity]. At most one in_ri bit is high per cycle.
//   - Transfer = in_si[i] && in_ri[i]. The flit is written to FIFO[polarity] at the clock edge.
//   - ptr <= (i+1) mod N_IN only on a transfer; otherwise ptr holds. This covers the FIFO-full case and the no-eligible case.
//  Egress:
//   - out_so = !empty[~polarity].
//   - out_do = head of FIFO[~polarity] when out_so=1, else all zeros.
//   - Pop when out_so && out_ro. Zero-latency read: the head flit is visible in the same cycle it becomes valid.
//  Latency: a flit accepted at edge k can appear on out_do in the first cycle after k in which polarity has flipped.
//  Simultaneity: push and pop always target different FIFOs, so there is no same-FIFO read/write hazard.
//   - A full FIFO never accepts a flit, even if the opposite FIFO pops that cycle.
//  Polarity toggle: takes effect combinationally.
//   - The source FIFO and sink FIFO swap in the same cycle; no flit is lost or duplicated.
//   - Pending grants are re-evaluated that cycle.
//  Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally.
//   - Full/empty are derived from occupancy counters: full = (occ==DEPTH), empty = (occ==0).
//   - Occupancy is +1 on push, -1 on pop; per FIFO it never moves both ways in one cycle.
//  Out-of-range: DW bits of a source are never modified; VC_BIT is the only field inspected.
// TESTING
//  1. Reset mid-stream:
//     - Stimulus: fill VC0 with 1 flit, then assert reset asynchronously between edges.
//     - Required: out_so=0, in_ri=0, occ_vc0=0 immediately; stays clean after release.
//  2. Round-robin fairness:
//     - Stimulus: polarity=0, all 4 sources hold VC0 flits, out_ro=1, polarity toggling every 2 cycles.
//     - Required: grants occur in order 0,1,2,3,0; no source is starved.
//  3. VC gating:
//     - Stimulus: polarity=1, src2 offers a flit with bit63=0 (0x0000_..._00AA).
//     - Required: in_ri[2]=0 until polarity=0; then the flit is accepted and appears on out_do after polarity returns to 1.
//  4. FIFO full / wrap:
//     - Stimulus: DEPTH=2, polarity=0, out_ro=0, three VC0 flits offered.
//     - Required: two accepted, occ_vc0=2, third held with in_ri=0 and ptr unchanged.
//     - Then: toggle polarity, out_ro=1; flits drain in FIFO order, occ_vc0 reaches 0 and pointers wrap.
//  5. Back-pressure:
//     - Stimulus: out_ro=0 while out_so=1.
//     - Required: out_do holds stable and occupancy is unchanged; the pop happens on the first cycle with out_ro=1.
//  6. Polarity flip with both VCs non-empty:
//     - Required: out_do switches to the other FIFO's head in the same cycle; no flit is lost or duplicated (scoreboard check).

Source files
------------

// File: rtl/output_controller_nvc.sv
// -----------------------------------------------------------------------------
// output_controller_nvc
//
// Output-port controller for one mesh-router link. N_IN sources compete through
// a round-robin arbiter. Accepted flits are queued in one of two per-VC FIFOs
// (DEPTH flits each). The polarity input selects the VC timeslot: flits whose
// VC flag equals polarity may enter FIFO[polarity], while FIFO[~polarity]
// drains onto the link.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   polarity  in   VC timeslot selector
//   in_si     in   [N_IN]        per-source valid
//   in_di     in   [N_IN*DW]     per-source flit, source i at [i*DW +: DW]
//   in_ri     out  [N_IN]        per-source ready (one-hot or zero)
//   out_so    out                link valid
//   out_do    out  [DW]          link flit (zero when out_so is low)
//   out_ro    in                 link ready
//   occ_vc0   out  [clog2(DEPTH)+1]  VC0 FIFO occupancy
//   occ_vc1   out  [clog2(DEPTH)+1]  VC1 FIFO occupancy
// -----------------------------------------------------------------------------
module output_controller_nvc #(
    parameter int N_IN   = 4,
    parameter int DW     = 64,
    parameter int VC_BIT = 63,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      polarity,
    input  logic [N_IN-1:0]           in_si,
    input  logic [N_IN*DW-1:0]        in_di,
    output logic [N_IN-1:0]           in_ri,
    output logic                      out_so,
    output logic [DW-1:0]             out_do,
    input  logic                      out_ro,
    output logic [$clog2(DEPTH):0]    occ_vc0,
    output logic [$clog2(DEPTH):0]    occ_vc1
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [PW-1:0] RR_ONE   = PW'(1);
    localparam logic [PW-1:0] RR_LAST  = PW'(N_IN - 1);

    // FIFO storage carries data only and is never reset.
    logic [DW-1:0]          mem_q [2][DEPTH];

    logic [1:0][AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [1:0][AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [1:0][AW:0]       occ_q,    occ_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;

    logic                   pol_n;
    logic [1:0]             full;
    logic [1:0]             empty;
    logic [N_IN-1:0]        elig;
    logic [N_IN-1:0]        grant;
    logic [PW-1:0]          gnt_idx;
    logic                   found;
    int                     rr_idx;
    logic                   push;
    logic                   pop;
    logic [DW-1:0]          push_flit;

    assign pol_n    = ~polarity;
    assign full[0]  = (occ_q[0] == OCC_FULL);
    assign full[1]  = (occ_q[1] == OCC_FULL);
    assign empty[0] = (occ_q[0] == '0);
    assign empty[1] = (occ_q[1] == '0);

    // Only the VC flag of each offered flit is inspected.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_IN; i++) begin
            elig[i] = in_si[i] && (in_di[i*DW + VC_BIT] == polarity);
        end
    end

    // Round-robin: first eligible source at or after rr_ptr_q, modulo N_IN.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        rr_idx  = int'(rr_ptr_q);
        for (int k = 0; k < N_IN; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (!found && elig[i] && (i == (rr_idx + k) % N_IN)) begin
                    grant[i] = 1'b1;
                    gnt_idx  = PW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

    // Ready is suppressed while reset is high, since an empty FIFO would
    // otherwise let the arbiter's grant through during reset.
    assign in_ri = (reset || full[polarity]) ? '0 : grant;
    assign push  = |(in_si & in_ri);

    always_comb begin
        push_flit = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                push_flit = in_di[i*DW +: DW];
            end
        end
    end

    // Egress reads the opposite FIFO with zero latency.
    assign out_so = !reset && !empty[pol_n];
    assign out_do = out_so ? mem_q[pol_n][rd_ptr_q[pol_n]] : '0;
    assign pop    = out_so && out_ro;

    assign occ_vc0 = occ_q[0];
    assign occ_vc1 = occ_q[1];

    // Push and pop always address different FIFOs, so each FIFO's occupancy
    // moves by at most one step per cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            wr_ptr_d[polarity] = wr_ptr_q[polarity] + PTR_ONE;
            occ_d[polarity]    = occ_q[polarity] + OCC_ONE;
            rr_ptr_d           = (gnt_idx == RR_LAST) ? '0 : gnt_idx + RR_ONE;
        end
        if (pop) begin
            rd_ptr_d[pol_n] = rd_ptr_q[pol_n] + PTR_ONE;
            occ_d[pol_n]    = occ_q[pol_n] - OCC_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[polarity][wr_ptr_q[polarity]] <= push_flit;
        end
    end

endmodule

// File: tb/tb_output_controller_nvc.sv
// Testbench for output_controller_nvc: fixed vector table, hand-written
// corner sequences, and randomized traffic checked against a queue-based
// reference model plus an end-to-end flit scoreboard.
module tb_output_controller_nvc;

    localparam int N_IN   = 4;
    localparam int DW     = 64;
    localparam int VC_BIT = 63;
    localparam int DEPTH  = 2;
    localparam int OW     = $clog2(DEPTH) + 1;
    localparam int BW     = N_IN * DW;

    localparam logic [BW-1:0] ALL0    = {64'h13, 64'h12, 64'h11, 64'h10};
    localparam logic [BW-1:0] SRC2_AA = {64'h0, 64'hAA, 64'h0, 64'h0};
    localparam logic [BW-1:0] SRC3_V1 = {64'h8000_0000_0000_0033, 192'h0};

    logic              clk = 1'b0;
    logic              reset;
    logic              polarity;
    logic [N_IN-1:0]   in_si;
    logic [BW-1:0]     in_di;
    logic [N_IN-1:0]   in_ri;
    logic              out_so;
    logic [DW-1:0]     out_do;
    logic              out_ro;
    logic [OW-1:0]     occ_vc0;
    logic [OW-1:0]     occ_vc1;

    output_controller_nvc #(
        .N_IN(N_IN), .DW(DW), .VC_BIT(VC_BIT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .in_si(in_si), .in_di(in_di), .in_ri(in_ri),
        .out_so(out_so), .out_do(out_do), .out_ro(out_ro),
        .occ_vc0(occ_vc0), .occ_vc1(occ_vc1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: one queue per VC plus the round-robin start index.
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    int            m_ptr = 0;

    // Scoreboard of flits the DUT accepted, per VC, in acceptance order.
    logic [DW-1:0] sb0[$];
    logic [DW-1:0] sb1[$];
    bit            sb_on = 1'b0;
    int            gnt_log[$];

    typedef struct {
        logic            pol;
        logic [N_IN-1:0] si;
        logic [BW-1:0]   di;
        logic            ro;
        logic [N_IN-1:0] ri;
        logic            so;
        logic [DW-1:0]   dout;
        logic [OW-1:0]   o0;
        logic [OW-1:0]   o1;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic pol, input logic [N_IN-1:0] si, input logic [BW-1:0] di,
                       input logic ro, input logic [N_IN-1:0] ri, input logic so,
                       input logic [DW-1:0] dout, input int o0, input int o1);
        vec_t v;
        v.pol = pol; v.si = si; v.di = di; v.ro = ro;
        v.ri = ri; v.so = so; v.dout = dout; v.o0 = OW'(o0); v.o1 = OW'(o1);
        tbl.push_back(v);
    endtask

    task automatic drive(input logic pol, input logic [N_IN-1:0] si, input logic [BW-1:0] di,
                         input logic ro);
        polarity = pol;
        in_si    = si;
        in_di    = di;
        out_ro   = ro;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic compare(input string name, input logic [N_IN-1:0] ri, input logic so,
                           input logic [DW-1:0] d, input logic [OW-1:0] o0, input logic [OW-1:0] o1);
        n_vec++;
        if (in_ri !== ri || out_so !== so || out_do !== d || occ_vc0 !== o0 || occ_vc1 !== o1) begin
            n_bad++;
            $display("FAIL %s @%0t: got ri=%b so=%b do=%h occ0=%0d occ1=%0d, want ri=%b so=%b do=%h occ0=%0d occ1=%0d",
                     name, $time, in_ri, out_so, out_do, occ_vc0, occ_vc1, ri, so, d, o0, o1);
        end
    endtask

    function automatic int m_size(input logic v);
        return v ? mq1.size() : mq0.size();
    endfunction

    function automatic logic [DW-1:0] m_head(input logic v);
        if (v) return (mq1.size() > 0) ? mq1[0] : '0;
        return (mq0.size() > 0) ? mq0[0] : '0;
    endfunction

    // Records DUT grants, accepted flits and popped flits for the scoreboard.
    task automatic sb_observe();
        logic [DW-1:0] f;
        logic [DW-1:0] e;
        for (int i = 0; i < N_IN; i++) begin
            if (in_ri[i]) begin
                gnt_log.push_back(i);
                if (sb_on && in_si[i]) begin
                    f = in_di[i*DW +: DW];
                    if (f[VC_BIT]) sb1.push_back(f);
                    else           sb0.push_back(f);
                end
            end
        end
        if (sb_on && out_so && out_ro) begin
            n_vec++;
            if ((polarity ? sb0.size() : sb1.size()) == 0) begin
                n_bad++;
                $display("FAIL sb_pop: got %h, want no pop (nothing accepted on that VC)", out_do);
            end else begin
                e = polarity ? sb0.pop_front() : sb1.pop_front();
                if (out_do !== e) begin
                    n_bad++;
                    $display("FAIL sb_pop: got %h, want %h", out_do, e);
                end
            end
        end
    endtask

    // One clock cycle checked against the reference model.
    task automatic mcycle(input string name, input logic pol, input logic [N_IN-1:0] si,
                          input logic [BW-1:0] di, input logic ro);
        int              g;
        logic [N_IN-1:0] e_ri;
        logic            e_so;
        logic [DW-1:0]   e_do;
        logic [DW-1:0]   f;
        drive(pol, si, di, ro);
        #4;
        g = -1;
        for (int k = 0; k < N_IN; k++) begin
            int idx;
            idx = (m_ptr + k) % N_IN;
            f   = di[idx*DW +: DW];
            if (g < 0 && si[idx] && f[VC_BIT] == pol) g = idx;
        end
        e_ri = '0;
        if (g >= 0 && m_size(pol) < DEPTH) e_ri = N_IN'(1) << g;
        e_so = m_size(!pol) > 0;
        e_do = e_so ? m_head(!pol) : '0;
        compare(name, e_ri, e_so, e_do, OW'(mq0.size()), OW'(mq1.size()));
        sb_observe();
        @(posedge clk);
        if (e_ri != '0) begin
            f = di[g*DW +: DW];
            if (pol) mq1.push_back(f);
            else     mq0.push_back(f);
            m_ptr = (g + 1) % N_IN;
        end
        if (e_so && ro) begin
            if (pol) void'(mq0.pop_front());
            else     void'(mq1.pop_front());
        end
        #1;
    endtask

    initial begin
        logic [BW-1:0] di;
        logic          pol;
        int            exp_g[5];

        // Reset state, with traffic already offered.
        reset = 1'b1;
        drive(1'b0, 4'b1111, ALL0, 1'b1);
        #3;
        chk("reset_in_ri", DW'(in_ri), '0);
        chk("reset_out_so", DW'(out_so), '0);
        chk("reset_occ0", DW'(occ_vc0), '0);
        chk("reset_occ1", DW'(occ_vc1), '0);
        drive(1'b0, 4'b0000, '0, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // Vector table: fill to full, ptr hold, drain, VC gating, swap.
        add(0, 4'b0000, '0,      0, 4'b0000, 0, 64'h0,  0, 0);
        add(0, 4'b1111, ALL0,    0, 4'b0001, 0, 64'h0,  0, 0);
        add(0, 4'b1111, ALL0,    0, 4'b0010, 0, 64'h0,  1, 0);
        add(0, 4'b1111, ALL0,    0, 4'b0000, 0, 64'h0,  2, 0);
        add(1, 4'b0000, ALL0,    0, 4'b0000, 1, 64'h10, 2, 0);
        add(1, 4'b0000, '0,      1, 4'b0000, 1, 64'h10, 2, 0);
        add(1, 4'b0000, '0,      1, 4'b0000, 1, 64'h11, 1, 0);
        add(1, 4'b0000, '0,      1, 4'b0000, 0, 64'h0,  0, 0);
        add(1, 4'b0100, SRC2_AA, 1, 4'b0000, 0, 64'h0,  0, 0);
        add(0, 4'b0100, SRC2_AA, 1, 4'b0100, 0, 64'h0,  0, 0);
        add(1, 4'b0000, '0,      0, 4'b0000, 1, 64'hAA, 1, 0);
        add(1, 4'b1000, SRC3_V1, 1, 4'b1000, 1, 64'hAA, 1, 0);
        add(1, 4'b0000, '0,      0, 4'b0000, 0, 64'h0,  0, 1);
        add(0, 4'b0000, '0,      1, 4'b0000, 1, 64'h8000_0000_0000_0033, 0, 1);
        add(0, 4'b0000, '0,      0, 4'b0000, 0, 64'h0,  0, 0);
        for (int v = 0; v < tbl.size(); v++) begin
            drive(tbl[v].pol, tbl[v].si, tbl[v].di, tbl[v].ro);
            #4;
            compare($sformatf("table[%0d]", v), tbl[v].ri, tbl[v].so, tbl[v].dout, tbl[v].o0, tbl[v].o1);
            @(posedge clk);
            #1;
        end

        // Reset asserted between edges with a flit in VC0.
        mq0.delete(); mq1.delete(); m_ptr = 0;
        mcycle("rst_fill", 1'b0, 4'b0001, {192'h0, 64'h55}, 1'b0);
        drive(1'b1, 4'b0000, '0, 1'b0);
        #1;
        chk("rst_pre_so", DW'(out_so), 64'h1);
        chk("rst_pre_do", out_do, 64'h55);
        reset = 1'b1;
        #1;
        chk("rst_so", DW'(out_so), '0);
        chk("rst_do", out_do, '0);
        chk("rst_occ0", DW'(occ_vc0), '0);
        drive(1'b0, 4'b1111, ALL0, 1'b1);
        #1;
        chk("rst_ri", DW'(in_ri), '0);
        @(posedge clk);
        #2;
        chk("rst_hold_occ0", DW'(occ_vc0), '0);
        chk("rst_hold_ri", DW'(in_ri), '0);
        drive(1'b0, 4'b0000, '0, 1'b0);
        #1 reset = 1'b0;
        mq0.delete(); mq1.delete(); m_ptr = 0;
        @(posedge clk);
        #1;
        mcycle("rst_after", 1'b1, 4'b0000, '0, 1'b1);

        // Round-robin fairness with polarity toggling every 2 cycles.
        sb_on = 1'b1;
        gnt_log.delete();
        for (int c = 0; c < 10; c++) begin
            di = '0;
            for (int i = 0; i < N_IN; i++) di[i*DW +: DW] = {32'h0, 16'(c), 16'(i)};
            mcycle("rr", 1'((c / 2) % 2), 4'b1111, di, 1'b1);
        end
        exp_g = '{0, 1, 2, 3, 0};
        chk("rr_count", DW'(gnt_log.size() >= 5), 64'h1);
        for (int i = 0; i < 5; i++) begin
            if (i < gnt_log.size())
                chk($sformatf("rr_grant[%0d]", i), DW'(gnt_log[i]), DW'(exp_g[i]));
        end

        // Polarity flips with both FIFOs holding flits.
        mcycle("flip_push_vc1", 1'b1, 4'b0001, {192'h0, 64'h8000_0000_0000_00F1}, 1'b0);
        mcycle("flip_to_vc1",   1'b0, 4'b0000, '0, 1'b0);
        mcycle("flip_to_vc0",   1'b1, 4'b0000, '0, 1'b0);
        mcycle("flip_pop_vc1",  1'b0, 4'b0000, '0, 1'b1);

        // Randomized traffic.
        pol = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) pol = ~pol;
            for (int i = 0; i < N_IN; i++) di[i*DW +: DW] = {$urandom, $urandom};
            mcycle("rand", pol, 4'($urandom_range(0, 15)), di, $urandom_range(0, 3) != 0);
        end

        // Drain both VCs and confirm every accepted flit came out.
        for (int c = 0; c < 4; c++) mcycle("drain_vc1", 1'b0, 4'b0000, '0, 1'b1);
        for (int c = 0; c < 4; c++) mcycle("drain_vc0", 1'b1, 4'b0000, '0, 1'b1);
        chk("end_occ0", DW'(occ_vc0), '0);
        chk("end_occ1", DW'(occ_vc1), '0);
        chk("end_sb0_left", DW'(sb0.size()), '0);
        chk("end_sb1_left", DW'(sb1.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
